// File: rtl/spart_tx.sv
// SPART transmit half: decodes bus writes for the baud divisor and a single
// buffered transmit byte, and serialises 8N1 frames on txd.
module spart_tx #(
  parameter logic [15:0] RESET_DIV = 16'd5207
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] databus,
  output logic       tbr,
  output logic       txd,
  output logic       tx_busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [15:0] div;
  logic [7:0]  buf_data;
  logic        buf_full;
  logic [1:0]  state, state_nx;
  logic [15:0] baud_cnt, baud_nx;
  logic [2:0]  bit_cnt, bit_nx;
  logic [7:0]  shifter, shifter_nx;
  logic        txd_nx;
  logic        wr, tick, load, buf_wr;

  assign wr      = iocs & ~iorw;
  assign tick    = (state != IDLE) && (baud_cnt == 16'd0);
  // A full buffer is taken either from idle or straight out of a finishing stop bit.
  assign load    = buf_full && ((state == IDLE) || ((state == STOP) && tick));
  assign buf_wr  = wr && (ioaddr == 2'd0) && !buf_full;
  assign tbr     = ~buf_full;
  assign tx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= RESET_DIV;
    end else if (wr && (ioaddr == 2'd2)) begin
      div[7:0] <= databus;
    end else if (wr && (ioaddr == 2'd3)) begin
      div[15:8] <= databus;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_data <= 8'h00;
      buf_full <= 1'b0;
    end else if (load) begin
      buf_full <= 1'b0;
    end else if (buf_wr) begin
      buf_data <= databus;
      buf_full <= 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    baud_nx    = baud_cnt;
    bit_nx     = bit_cnt;
    shifter_nx = shifter;
    if (load) begin
      state_nx   = START;
      baud_nx    = div;
      bit_nx     = 3'd0;
      shifter_nx = buf_data;
    end else if (state != IDLE) begin
      if (tick) begin
        // Reload picks up whatever divisor is current, so bits in flight keep their length.
        baud_nx = div;
        case (state)
          START: state_nx = DATA;
          DATA: begin
            if (bit_cnt == 3'd7) begin
              state_nx = STOP;
            end else begin
              shifter_nx = {1'b0, shifter[7:1]};
              bit_nx     = bit_cnt + 3'd1;
            end
          end
          STOP:    state_nx = IDLE;
          default: state_nx = IDLE;
        endcase
      end else begin
        baud_nx = baud_cnt - 16'd1;
      end
    end
  end

  always_comb begin
    txd_nx = 1'b1;
    case (state_nx)
      START:   txd_nx = 1'b0;
      DATA:    txd_nx = shifter_nx[0];
      default: txd_nx = 1'b1;
    endcase
  end

  // txd is registered from the next-state view so the line changes on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
      shifter  <= 8'h00;
      txd      <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_cnt  <= bit_nx;
      shifter  <= shifter_nx;
      txd      <= txd_nx;
    end
  end

endmodule

// File: tb/tb_spart_tx.sv
// Bench for spart_tx: a bit-level frame model checked every cycle, plus
// hand-computed expectations for the directed scenarios.
module tb_spart_tx;

  localparam logic [15:0] RESET_DIV = 16'd5207;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'd0;
  logic [7:0] databus = 8'h00;
  logic       tbr, txd, tx_busy;

  int vectors = 0;
  int miscompares = 0;

  spart_tx #(.RESET_DIV(RESET_DIV)) dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .tbr(tbr), .txd(txd), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // Model: a frame is ten bits (start, 8 data LSB first, stop), each lasting div+1 clocks.
  logic [15:0] m_div = RESET_DIV;
  logic        m_full = 1'b0;
  logic [7:0]  m_buf = 8'h00;
  logic        m_active = 1'b0;
  logic [7:0]  m_byte = 8'h00;
  int          m_bit = 0;
  int          m_left = 0;
  logic        m_was_full;
  logic [7:0]  m_log[$];

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_div = RESET_DIV; m_full = 1'b0; m_active = 1'b0; m_bit = 0; m_left = 0;
    end else begin
      m_was_full = m_full;
      if (m_active) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_bit < 9) begin
            m_bit = m_bit + 1;
            m_left = int'(m_div) + 1;
          end else if (m_full) begin
            m_byte = m_buf; m_full = 1'b0; m_bit = 0; m_left = int'(m_div) + 1;
            m_log.push_back(m_buf);
          end else begin
            m_active = 1'b0;
          end
        end
      end else if (m_full) begin
        m_active = 1'b1; m_byte = m_buf; m_full = 1'b0; m_bit = 0; m_left = int'(m_div) + 1;
        m_log.push_back(m_buf);
      end
      if (iocs && !iorw) begin
        if (ioaddr == 2'd0 && !m_was_full) begin
          m_buf = databus; m_full = 1'b1;
        end else if (ioaddr == 2'd2) begin
          m_div[7:0] = databus;
        end else if (ioaddr == 2'd3) begin
          m_div[15:8] = databus;
        end
      end
    end
  end

  logic exp_txd, exp_tbr, exp_busy;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_busy = m_active;
      exp_tbr  = !m_full;
      if (!m_active)        exp_txd = 1'b1;
      else if (m_bit == 0)  exp_txd = 1'b0;
      else if (m_bit == 9)  exp_txd = 1'b1;
      else                  exp_txd = m_byte[m_bit-1];
      vectors++;
      if (txd !== exp_txd || tbr !== exp_tbr || tx_busy !== exp_busy) begin
        miscompares++;
        $display("[TB] FAIL cycle_model t=%0t txd/tbr/busy got %b%b%b want %b%b%b",
                 $time, txd, tbr, tx_busy, exp_txd, exp_tbr, exp_busy);
      end
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cs, input logic rw, input logic [1:0] addr,
                               input logic [7:0] data);
    iocs = cs; iorw = rw; ioaddr = addr; databus = data;
    step(1);
    iocs = 1'b0; iorw = 1'b0; ioaddr = 2'd0; databus = 8'h00;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Counts clocks with tx_busy high, starting from the edge after a buffer write.
  task automatic measure_busy(output int n);
    n = 0;
    step(1);
    while (n < 70000) begin
      @(negedge clk);
      if (!tx_busy) break;
      n++;
      step(1);
    end
  endtask

  logic [9:0] frame_a5;
  int log_base;
  int busy_len;

  initial begin
    #3 rst = 1'b0;
    step(3);
    checkOutput("reset_txd", int'(txd), 1);
    checkOutput("reset_tbr", int'(tbr), 1);
    checkOutput("reset_busy", int'(tx_busy), 0);
    rst = 1'b1;
    step(2);

    $display("[TB] div=3, byte 0xA5");
    applyStimulus(1'b1, 1'b0, 2'd2, 8'h03);
    applyStimulus(1'b1, 1'b0, 2'd3, 8'h00);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'hA5);
    @(negedge clk);
    checkOutput("a5_tbr_low", int'(tbr), 0);
    frame_a5 = 10'b11_0100_1010;
    for (int i = 0; i < 40; i++) begin
      step(1);
      @(negedge clk);
      if (i == 0) checkOutput("a5_tbr_back", int'(tbr), 1);
      checkOutput($sformatf("a5_txd_%0d", i), int'(txd), int'(frame_a5[i/4]));
    end
    step(1);
    @(negedge clk);
    checkOutput("a5_idle_txd", int'(txd), 1);
    checkOutput("a5_idle_busy", int'(tx_busy), 0);

    $display("[TB] div=1, 0x55 then 0x0F during start");
    step(1);
    applyStimulus(1'b1, 1'b0, 2'd2, 8'h01);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h55);
    step(1);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h0F);
    step(18);
    @(negedge clk);
    checkOutput("b2b_stop_txd", int'(txd), 1);
    checkOutput("b2b_stop_tbr", int'(tbr), 0);
    step(1);
    @(negedge clk);
    checkOutput("b2b_start_txd", int'(txd), 0);
    checkOutput("b2b_start_tbr", int'(tbr), 1);
    step(25);

    $display("[TB] 0x11, 0x22, 0x33 with 0x33 dropped");
    log_base = m_log.size();
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h11);
    step(1);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h22);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h33);
    @(negedge clk);
    checkOutput("drop_tbr", int'(tbr), 0);
    step(45);
    checkOutput("drop_count", m_log.size() - log_base, 2);
    if (m_log.size() >= log_base + 2) begin
      checkOutput("drop_first", int'(m_log[log_base]), 32'h11);
      checkOutput("drop_second", int'(m_log[log_base+1]), 32'h22);
    end

    $display("[TB] div=7, 0xFF, divisor changed mid-data");
    applyStimulus(1'b1, 1'b0, 2'd2, 8'h07);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'hFF);
    step(19);
    applyStimulus(1'b1, 1'b0, 2'd2, 8'h01);
    step(18);
    @(negedge clk);
    checkOutput("divchg_busy_end", int'(tx_busy), 1);
    step(1);
    @(negedge clk);
    checkOutput("divchg_idle", int'(tx_busy), 0);
    checkOutput("divchg_txd", int'(txd), 1);

    $display("[TB] reset mid-data");
    step(1);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h3C);
    step(1);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h81);
    step(4);
    checkOutput("pre_rst_txd", int'(txd), 0);
    checkOutput("pre_rst_tbr", int'(tbr), 0);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_txd", int'(txd), 1);
    checkOutput("async_rst_tbr", int'(tbr), 1);
    checkOutput("async_rst_busy", int'(tx_busy), 0);
    step(3);
    rst = 1'b1;
    step(1);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h5A);
    measure_busy(busy_len);
    checkOutput("reset_div_frame", busy_len, 52080);

    $display("[TB] div=0, one bit per clock");
    step(2);
    applyStimulus(1'b1, 1'b0, 2'd2, 8'h00);
    applyStimulus(1'b1, 1'b0, 2'd3, 8'h00);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'hC3);
    measure_busy(busy_len);
    checkOutput("div0_frame", busy_len, 10);

    $display("[TB] ignored accesses");
    step(2);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h77);
    @(negedge clk);
    checkOutput("nocs_tbr", int'(tbr), 1);
    step(1);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h77);
    @(negedge clk);
    checkOutput("read_tbr", int'(tbr), 1);
    step(1);
    applyStimulus(1'b1, 1'b0, 2'd1, 8'h77);
    step(3);
    @(negedge clk);
    checkOutput("ignored_tbr", int'(tbr), 1);
    checkOutput("ignored_txd", int'(txd), 1);
    checkOutput("ignored_busy", int'(tx_busy), 0);

    step(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spart_tx.md
Name: spart_tx

Overview:
- Transmit half of the SPART, directly downstream of the bus driver.
- Decodes driver writes on iocs/iorw/ioaddr/databus and holds the 16-bit baud divisor (ioaddr 2 = low byte, ioaddr 3 = high byte).
- Double-buffers one transmit byte (ioaddr 0) and serialises 8N1 frames on txd, reporting buffer-empty to the driver on tbr.
- Read-side registers (receive buffer, status) live in the receive/bus block; this block never drives databus.

Parameters:
- RESET_DIV, 16'd5207, divisor loaded at reset (bit period = divisor+1 clocks).

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  asynchronous active-low reset.
- iocs  input  1  chip select; a bus access is valid only when high.
- iorw  input  1  1 = read, 0 = write.
- ioaddr  input  2  0 = TX buffer, 1 = status (ignored here), 2 = DB low, 3 = DB high.
- databus  input  8  receive-only tap of the shared bus.
- tbr  output  1  transmit buffer ready (buffer empty).
- txd  output  1  serial out, idle high.
- tx_busy  output  1  shifter active (START/DATA/STOP).

Behaviour:
- Reset (rst low, asynchronous):
  - Register values: divisor = RESET_DIV; buffer empty; state IDLE; baud counter 0; bit count 0.
  - Outputs: txd = 1, tbr = 1, tx_busy = 0.
- Write strobe: wr = iocs & ~iorw, sampled on posedge. All accesses with iorw = 1, and ioaddr 1 writes, have no effect.
- Divisor writes:
  - ioaddr 2 write: div[7:0] <= databus. ioaddr 3 write: div[15:8] <= databus.
  - The running baud counter is not modified; a new divisor takes effect at the next counter reload, so the current bit is never truncated.
- Buffer writes:
  - ioaddr 0 write while buffer empty: buf <= databus, buffer full, tbr = 0 from the next cycle.
  - Write while buffer full: dropped silently; buf and tbr unchanged.
- Transfer:
  - Condition: state is IDLE and buffer full.
  - Next edge: shifter <= buf, buffer empty (tbr = 1), state START, baud counter <= div, bit count <= 0.
  - Transfer and a new ioaddr 0 write in the same cycle: transfer wins that cycle. The write sees the buffer as full and is dropped.
- Baud counter:
  - Decrements by 1 each cycle while not IDLE.
  - When it is 0, a tick occurs and it reloads from div.
  - Each bit therefore lasts div+1 cycles; div = 0 gives one bit per clock.
- State machine (transitions on tick only):
  - IDLE: txd = 1. Leaves only via transfer.
  - START: txd = 0. tick -> DATA.
  - DATA: txd = shifter[0], LSB first.
    - tick with bit count < 7: shift right, bit count + 1.
    - tick with bit count = 7: -> STOP.
  - STOP: txd = 1. On tick:
    - buffer full -> START with an immediate reload (no idle bit between frames).
    - buffer empty -> IDLE.
- txd is driven from a register, with no combinational path from bus inputs.
- tx_busy = (state != IDLE).
- Frame length: exactly 10*(div+1) clocks from the first txd = 0 cycle to the end of stop.
- Reset mid-frame: txd returns to 1 immediately (asynchronously); any partial frame and the buffered byte are lost.
- Divisor edge values:
  - div = 16'hFFFF: 65536-cycle bits.
  - The counter is 16 bits and never wraps past the reload.

Test Plan:
- Reset, then write 0x03 @2 and 0x00 @3, then 0xA5 @0:
  - tbr falls one cycle after the write and rises the cycle after transfer.
  - txd sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1.
  - Frame is 40 clocks; txd = 1 and tx_busy = 0 afterwards.
- div = 1, write 0x55, then write 0x0F during the START bit:
  - Second frame begins on the cycle after the first stop bit ends, with no idle gap.
  - tbr = 1 once 0x0F is transferred.
- div = 1, write 0x11 then 0x22 then 0x33 back-to-back while 0x11 is shifting:
  - 0x33 is dropped (buffer full).
  - Output is 0x11 then 0x22 only.
- div = 7, send 0xFF; write 0x01 @2 mid-DATA:
  - The current bit still lasts 8 cycles.
  - Following bits last 2 cycles.
  - Bits are not corrupted.
- Assert rst low mid-DATA:
  - txd = 1 and tbr = 1 asynchronously, with no waiting for a clock edge.
  - Divisor returns to RESET_DIV (verified by a frame of 5208-cycle bits).
- iocs = 0 with iorw = 0, ioaddr 0, databus 0x77, and iocs = 1 with iorw = 1 to addr 0:
  - No buffer load; tbr stays 1; txd stays 1.
